fastdac_dpram_loader: RTL and testbench

//  Burst write engine and arbiter for the fast-DAC lookup DPRAMs: the sequence table and the RNG table.
//  Two AXI-Stream sources share it: a host config stream (headered bursts, either table) and a live
//  RNG refill stream (RNG table only, ring buffer). Drives the *_wen/addr/din write ports, the
//  max-address registers and dac1_shift_en_o of the DAC1 sample path.

---
 rtl/fastdac_dpram_loader.sv | 211 +++++++++++++++++++++
 tb/tb_fastdac_dpram_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastdac_dpram_loader.sv
// Burst write engine for the fast-DAC sequence and RNG lookup DPRAMs.
// Arbitrates a headered host config stream against a ring-buffer RNG refill stream.
module fastdac_dpram_loader #(
    parameter int SEQ_AW        = 10,
    parameter int RNG_AW        = 12,
    parameter int MAX_RNG_BURST = 64
) (
    input  logic              s_axis_clk,
    input  logic              s_axis_tresetn,
    input  logic [31:0]       host_tdata,
    input  logic              host_tvalid,
    input  logic              host_tlast,
    output logic              host_tready,
    input  logic [31:0]       rng_tdata,
    input  logic              rng_tvalid,
    input  logic              rng_tlast,
    output logic              rng_tready,
    output logic              fastdac_sequence_wen_int,
    output logic [SEQ_AW-1:0] fastdac_sequence_addr_int,
    output logic [31:0]       fastdac_sequence_din_int,
    output logic              fastdac_rng_wen_int,
    output logic [RNG_AW-1:0] fastdac_rng_addr_int,
    output logic [31:0]       fastdac_rng_din_int,
    output logic [SEQ_AW-1:0] fastdac_dpram_max_addr_seq_dac1_int,
    output logic [RNG_AW-1:0] fastdac_dpram_max_addr_rng_dac1_int,
    output logic              dac1_shift_en_o,
    output logic              busy_o,
    output logic              err_overflow_o
);

    localparam int CW = $clog2(MAX_RNG_BURST + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(MAX_RNG_BURST - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [RNG_AW:0]   ADDR_ONE = (RNG_AW+1)'(1);
    localparam logic [RNG_AW-1:0] PTR_ONE  = RNG_AW'(1);
    localparam logic [RNG_AW-1:0] SEQ_MASK = RNG_AW'((64'(1) << SEQ_AW) - 64'(1));

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        H_DATA,
        R_DATA
    } state_t;

    state_t            state;
    logic              last_host;
    logic              tgt_rng;
    logic              wrote;
    logic [RNG_AW:0]   addr;
    logic [RNG_AW-1:0] last_wr;
    logic [RNG_AW-1:0] rng_ptr;
    logic [CW-1:0]     cnt;

    logic              host_hs;
    logic              rng_hs;
    logic              addr_ok;
    logic [RNG_AW-1:0] hdr_base;
    logic              hdr_seq_hi;
    logic              unused_hdr_bits;

    assign host_hs  = host_tready && host_tvalid;
    assign rng_hs   = rng_tready && rng_tvalid;
    assign hdr_base = host_tdata[RNG_AW-1:0];

    // Seq bursts only address the low SEQ_AW bits of the header base field
    assign hdr_seq_hi = |(hdr_base & ~SEQ_MASK);
    assign unused_hdr_bits = ^host_tdata[30:RNG_AW];

    always_comb begin
        addr_ok = 1'b0;
        if (tgt_rng) begin
            addr_ok = !addr[RNG_AW];
        end else begin
            addr_ok = (addr[RNG_AW:SEQ_AW] == '0);
        end
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_tresetn) begin
        if (!s_axis_tresetn) begin
            state                               <= IDLE;
            last_host                           <= 1'b0;
            tgt_rng                             <= 1'b0;
            wrote                               <= 1'b0;
            addr                                <= '0;
            last_wr                             <= '0;
            rng_ptr                             <= '0;
            cnt                                 <= '0;
            host_tready                         <= 1'b0;
            rng_tready                          <= 1'b0;
            fastdac_sequence_wen_int            <= 1'b0;
            fastdac_sequence_addr_int           <= '0;
            fastdac_sequence_din_int            <= '0;
            fastdac_rng_wen_int                 <= 1'b0;
            fastdac_rng_addr_int                <= '0;
            fastdac_rng_din_int                 <= '0;
            fastdac_dpram_max_addr_seq_dac1_int <= '0;
            fastdac_dpram_max_addr_rng_dac1_int <= '0;
            dac1_shift_en_o                     <= 1'b0;
            busy_o                              <= 1'b0;
            err_overflow_o                      <= 1'b0;
        end else begin
            fastdac_sequence_wen_int <= 1'b0;
            fastdac_rng_wen_int      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (host_tvalid && (!rng_tvalid || !last_host)) begin
                        state       <= HDR;
                        host_tready <= 1'b1;
                        busy_o      <= 1'b1;
                    end else if (rng_tvalid) begin
                        state      <= R_DATA;
                        rng_tready <= 1'b1;
                        busy_o     <= 1'b1;
                        cnt        <= '0;
                    end
                end

                HDR: begin
                    if (host_hs) begin
                        tgt_rng <= host_tdata[31];
                        if (!host_tdata[31] && hdr_seq_hi) begin
                            err_overflow_o <= 1'b1;
                        end
                        if (host_tlast) begin
                            state       <= IDLE;
                            host_tready <= 1'b0;
                            busy_o      <= 1'b0;
                            last_host   <= 1'b1;
                        end else begin
                            state <= H_DATA;
                            wrote <= 1'b0;
                            if (host_tdata[31]) begin
                                addr <= {1'b0, hdr_base};
                            end else begin
                                addr            <= {1'b0, hdr_base & SEQ_MASK};
                                dac1_shift_en_o <= 1'b0;
                            end
                        end
                    end
                end

                H_DATA: begin
                    if (host_hs) begin
                        if (addr_ok) begin
                            // Saturate once past the end so a long burst never wraps back
                            addr    <= addr + ADDR_ONE;
                            wrote   <= 1'b1;
                            last_wr <= addr[RNG_AW-1:0];
                            if (tgt_rng) begin
                                fastdac_rng_wen_int  <= 1'b1;
                                fastdac_rng_addr_int <= addr[RNG_AW-1:0];
                                fastdac_rng_din_int  <= host_tdata;
                            end else begin
                                fastdac_sequence_wen_int  <= 1'b1;
                                fastdac_sequence_addr_int <= addr[SEQ_AW-1:0];
                                fastdac_sequence_din_int  <= host_tdata;
                            end
                        end else begin
                            err_overflow_o <= 1'b1;
                        end
                        if (host_tlast) begin
                            state       <= IDLE;
                            host_tready <= 1'b0;
                            busy_o      <= 1'b0;
                            last_host   <= 1'b1;
                            if (tgt_rng) begin
                                if (addr_ok) begin
                                    fastdac_dpram_max_addr_rng_dac1_int <= addr[RNG_AW-1:0];
                                end else if (wrote) begin
                                    fastdac_dpram_max_addr_rng_dac1_int <= last_wr;
                                end
                            end else begin
                                dac1_shift_en_o <= 1'b1;
                                if (addr_ok) begin
                                    fastdac_dpram_max_addr_seq_dac1_int <= addr[SEQ_AW-1:0];
                                end else if (wrote) begin
                                    fastdac_dpram_max_addr_seq_dac1_int <= last_wr[SEQ_AW-1:0];
                                end
                            end
                        end
                    end
                end

                R_DATA: begin
                    if (rng_hs) begin
                        fastdac_rng_wen_int  <= 1'b1;
                        fastdac_rng_addr_int <= rng_ptr;
                        fastdac_rng_din_int  <= rng_tdata;
                        rng_ptr              <= rng_ptr + PTR_ONE;
                        cnt                  <= cnt + CNT_ONE;
                        if (rng_tlast || (cnt == CNT_LAST)) begin
                            state      <= IDLE;
                            rng_tready <= 1'b0;
                            busy_o     <= 1'b0;
                            last_host  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    host_tready <= 1'b0;
                    rng_tready  <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fastdac_dpram_loader.sv
// Directed bench for fastdac_dpram_loader: table bursts, overflow, arbitration,
// RNG ring wrap, header-only bursts and asynchronous reset.
module tb_fastdac_dpram_loader;

    localparam int SEQ_AW = 10;
    localparam int RNG_AW = 12;
    localparam int MAXB   = 64;
    localparam int LIM    = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       host_tdata;
    logic              host_tvalid;
    logic              host_tlast;
    logic              host_tready;
    logic [31:0]       rng_tdata;
    logic              rng_tvalid;
    logic              rng_tlast;
    logic              rng_tready;
    logic              seq_wen;
    logic [SEQ_AW-1:0] seq_addr;
    logic [31:0]       seq_din;
    logic              rng_wen;
    logic [RNG_AW-1:0] rng_addr;
    logic [31:0]       rng_din;
    logic [SEQ_AW-1:0] max_seq;
    logic [RNG_AW-1:0] max_rng;
    logic              shift_en;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    fastdac_dpram_loader #(
        .SEQ_AW        (SEQ_AW),
        .RNG_AW        (RNG_AW),
        .MAX_RNG_BURST (MAXB)
    ) dut (
        .s_axis_clk                          (clk),
        .s_axis_tresetn                      (rst_n),
        .host_tdata                          (host_tdata),
        .host_tvalid                         (host_tvalid),
        .host_tlast                          (host_tlast),
        .host_tready                         (host_tready),
        .rng_tdata                           (rng_tdata),
        .rng_tvalid                          (rng_tvalid),
        .rng_tlast                           (rng_tlast),
        .rng_tready                          (rng_tready),
        .fastdac_sequence_wen_int            (seq_wen),
        .fastdac_sequence_addr_int           (seq_addr),
        .fastdac_sequence_din_int            (seq_din),
        .fastdac_rng_wen_int                 (rng_wen),
        .fastdac_rng_addr_int                (rng_addr),
        .fastdac_rng_din_int                 (rng_din),
        .fastdac_dpram_max_addr_seq_dac1_int (max_seq),
        .fastdac_dpram_max_addr_rng_dac1_int (max_rng),
        .dac1_shift_en_o                     (shift_en),
        .busy_o                              (busy),
        .err_overflow_o                      (err)
    );

    logic [28:0] ctrl_v;
    logic [53:0] port_v;
    assign ctrl_v = {host_tready, rng_tready, seq_wen, rng_wen,
                     max_seq, max_rng, shift_en, busy, err};
    assign port_v = {seq_addr, rng_addr, seq_din};

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;
    int unsigned seq_a[$];
    int unsigned seq_d[$];
    int unsigned seq_r[$];
    int unsigned rng_a[$];
    int unsigned rng_d[$];

    always @(negedge clk) begin
        if (seq_wen && rng_wen) both_cnt++;
        if (seq_wen) begin
            seq_a.push_back(32'(seq_addr));
            seq_d.push_back(seq_din);
            seq_r.push_back(32'(rng_a.size()));
        end
        if (rng_wen) begin
            rng_a.push_back(32'(rng_addr));
            rng_d.push_back(rng_din);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        seq_a.delete();
        seq_d.delete();
        seq_r.delete();
        rng_a.delete();
        rng_d.delete();
    endtask

    task automatic host_word(input logic [31:0] d, input logic last);
        int n;
        host_tdata  = d;
        host_tlast  = last;
        host_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!host_tready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("host_hs_wait", 64'(n >= LIM), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic host_stop();
        host_tvalid = 1'b0;
        host_tlast  = 1'b0;
    endtask

    task automatic rng_word(input logic [31:0] d, input logic last);
        int n;
        rng_tdata  = d;
        rng_tlast  = last;
        rng_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rng_tready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("rng_hs_wait", 64'(n >= LIM), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rng_stream(input int cnt, input logic [31:0] base, input logic use_last);
        for (int i = 0; i < cnt; i++) begin
            rng_word(base + 32'(i), use_last && (i == cnt - 1));
        end
        rng_tvalid = 1'b0;
        rng_tlast  = 1'b0;
    endtask

    initial begin
        int bad;
        int n;
        rst_n       = 1'b0;
        host_tdata  = '0;
        host_tvalid = 1'b0;
        host_tlast  = 1'b0;
        rng_tdata   = '0;
        rng_tvalid  = 1'b0;
        rng_tlast   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'(ctrl_v), 64'(0));
        chk("rst_ports", 64'(port_v), 64'(0));
        chk("rst_rng_din", 64'(rng_din), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: seq burst at base 0
        clear_logs();
        host_word(32'h0000_0000, 1'b0);
        chk("t1_busy_hdr", 64'(busy), 64'(1));
        for (int i = 0; i < 4; i++) begin
            host_word(32'hA0A0_0000 + 32'(i), i == 3);
            chk("t1_wen", 64'(seq_wen), 64'(1));
            chk("t1_addr", 64'(seq_addr), 64'(i));
            chk("t1_din", 64'(seq_din), 64'(32'hA0A0_0000 + 32'(i)));
            chk("t1_rng_wen", 64'(rng_wen), 64'(0));
            if (i < 3) chk("t1_shift_mid", 64'(shift_en), 64'(0));
        end
        host_stop();
        chk("t1_max_seq", 64'(max_seq), 64'(3));
        chk("t1_shift_end", 64'(shift_en), 64'(1));
        @(posedge clk);
        #1;
        chk("t1_wen_off", 64'(seq_wen), 64'(0));
        chk("t1_busy_end", 64'(busy), 64'(0));
        chk("t1_nwrites", 64'(seq_a.size()), 64'(4));

        // 2: RNG-table host burst running off the end
        host_word(32'h8000_0FFE, 1'b0);
        host_word(32'hB000_0000, 1'b0);
        chk("t2_wen0", 64'(rng_wen), 64'(1));
        chk("t2_addr0", 64'(rng_addr), 64'(12'hFFE));
        host_word(32'hB000_0001, 1'b0);
        chk("t2_wen1", 64'(rng_wen), 64'(1));
        chk("t2_addr1", 64'(rng_addr), 64'(12'hFFF));
        chk("t2_din1", 64'(rng_din), 64'(32'hB000_0001));
        chk("t2_err_pre", 64'(err), 64'(0));
        host_word(32'hB000_0002, 1'b1);
        host_stop();
        chk("t2_wen_drop", 64'(rng_wen), 64'(0));
        chk("t2_seq_wen", 64'(seq_wen), 64'(0));
        chk("t2_err", 64'(err), 64'(1));
        chk("t2_max_rng", 64'(max_rng), 64'(12'hFFF));
        chk("t2_shift_kept", 64'(shift_en), 64'(1));

        // 5: header-only burst
        clear_logs();
        host_tdata  = 32'h0000_0005;
        host_tlast  = 1'b1;
        host_tvalid = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy_hdr", 64'(busy), 64'(1));
        chk("t5_tready", 64'(host_tready), 64'(1));
        @(posedge clk);
        #1;
        host_stop();
        chk("t5_busy_after", 64'(busy), 64'(0));
        chk("t5_tready_after", 64'(host_tready), 64'(0));
        @(posedge clk);
        #1;
        chk("t5_nwrites", 64'(seq_a.size() + rng_a.size()), 64'(0));
        chk("t5_shift", 64'(shift_en), 64'(1));
        chk("t5_max_seq", 64'(max_seq), 64'(3));
        chk("t5_max_rng", 64'(max_rng), 64'(12'hFFF));

        // 6: asynchronous reset in the middle of a seq burst
        host_word(32'h0000_0000, 1'b0);
        host_word(32'hC000_0000, 1'b0);
        host_word(32'hC000_0001, 1'b0);
        chk("t6_wen_pre", 64'(seq_wen), 64'(1));
        host_tdata = 32'hC000_0002;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 64'(ctrl_v), 64'(0));
        chk("t6_rst_ports", 64'(port_v), 64'(0));
        host_stop();
        @(posedge clk);
        #1;
        chk("t6_rst_hold", 64'(ctrl_v), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        host_word(32'h0000_0000, 1'b0);
        host_word(32'hD000_0000, 1'b0);
        chk("t6_addr0", 64'(seq_addr), 64'(0));
        chk("t6_din0", 64'(seq_din), 64'(32'hD000_0000));
        host_word(32'hD000_0001, 1'b1);
        host_stop();
        chk("t6_addr1", 64'(seq_addr), 64'(1));
        chk("t6_max_seq", 64'(max_seq), 64'(1));
        @(posedge clk);
        #1;

        // 4: RNG ring wrap, starting from the reset pointer
        clear_logs();
        rng_stream(4100, 32'h4000_0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_count", 64'(rng_a.size()), 64'(4100));
        bad = 0;
        n = (rng_a.size() < 4100) ? rng_a.size() : 4100;
        for (int i = 0; i < n; i++) begin
            if (rng_a[i] != 32'(i % 4096)) bad++;
            if (rng_d[i] != 32'h4000_0000 + 32'(i)) bad++;
        end
        chk("t4_ring", 64'(bad), 64'(0));
        chk("t4_err", 64'(err), 64'(0));
        chk("t4_max_rng", 64'(max_rng), 64'(0));
        chk("t4_seq_none", 64'(seq_a.size()), 64'(0));

        // 3: both streams contend, RNG forced to re-arbitrate every 64 words
        clear_logs();
        both_cnt = 0;
        fork
            begin
                host_word(32'h0000_0020, 1'b0);
                for (int i = 0; i < 3; i++) host_word(32'hE000_0000 + 32'(i), i == 2);
                host_word(32'h0000_0040, 1'b0);
                for (int i = 0; i < 3; i++) host_word(32'hF000_0000 + 32'(i), i == 2);
                host_stop();
            end
            begin
                rng_stream(200, 32'h3000_0000, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("t3_seq_count", 64'(seq_a.size()), 64'(6));
        chk("t3_rng_count", 64'(rng_a.size()), 64'(200));
        chk("t3_both_wen", 64'(both_cnt), 64'(0));
        bad = 0;
        n = (seq_a.size() < 6) ? seq_a.size() : 6;
        for (int i = 0; i < n; i++) begin
            if (seq_a[i] != ((i < 3) ? 32'h20 + 32'(i) : 32'h40 + 32'(i - 3))) bad++;
            if (seq_d[i] != ((i < 3) ? 32'hE000_0000 + 32'(i) : 32'hF000_0000 + 32'(i - 3))) bad++;
            if (seq_r[i] != ((i < 3) ? 32'd0 : 32'd64)) bad++;
        end
        chk("t3_seq_order", 64'(bad), 64'(0));
        bad = 0;
        n = (rng_a.size() < 200) ? rng_a.size() : 200;
        for (int i = 0; i < n; i++) begin
            if (rng_a[i] != 32'((4 + i) % 4096)) bad++;
            if (rng_d[i] != 32'h3000_0000 + 32'(i)) bad++;
        end
        chk("t3_rng_ptr", 64'(bad), 64'(0));
        chk("t3_max_seq", 64'(max_seq), 64'(10'h042));
        chk("t3_shift", 64'(shift_en), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
